// File: rtl/iter_div32.sv
// Iterative 32-bit restoring divider (DIV/DIVU) with a fixed 33-cycle latency.
// The trial subtraction uses a 32-bit CLA adder; bit 32 of the trial is resolved locally.

module cla32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        aluc,
    output logic [31:0] s,
    output logic        cout
);
    logic [31:0] bx;
    logic [31:0] g;
    logic [31:0] p;
    logic [32:0] c;
    logic [7:0]  gg;
    logic [7:0]  gp;

    assign bx   = b ^ {32{aluc}};
    assign g    = a & bx;
    assign p    = a ^ bx;
    assign c[0] = aluc;

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_grp
            localparam int B = gi * 4;
            // Carries inside a 4-bit group are flattened lookahead terms.
            assign c[B+1] = g[B] | (p[B] & c[B]);
            assign c[B+2] = g[B+1] | (p[B+1] & g[B]) | (p[B+1] & p[B] & c[B]);
            assign c[B+3] = g[B+2] | (p[B+2] & g[B+1]) | (p[B+2] & p[B+1] & g[B])
                          | (p[B+2] & p[B+1] & p[B] & c[B]);
            assign gg[gi] = g[B+3] | (p[B+3] & g[B+2]) | (p[B+3] & p[B+2] & g[B+1])
                          | (p[B+3] & p[B+2] & p[B+1] & g[B]);
            assign gp[gi] = &p[B+3:B];
            assign c[B+4] = gg[gi] | (gp[gi] & c[B]);
        end
    endgenerate

    assign s    = p ^ c[31:0];
    assign cout = c[32];
endmodule

module iter_div32 (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        is_signed,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic [31:0] q,
    output logic [31:0] r,
    output logic        busy,
    output logic        done,
    output logic        dz
);
    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t      state_reg, state_next;
    logic [4:0]  cnt_reg, cnt_next;
    logic [31:0] rem_reg, rem_next;
    logic [31:0] quo_reg, quo_next;
    logic [31:0] dmag_reg, dmag_next;
    logic [31:0] a_reg, a_next;
    logic [31:0] b_reg, b_next;
    logic        sgn_reg, sgn_next;
    logic [31:0] q_reg, q_next;
    logic [31:0] r_reg, r_next;
    logic        dz_reg, dz_next;
    logic        done_reg, done_next;

    logic [31:0] trial_lo;
    logic [31:0] diff;
    logic        no_borrow;
    logic        take;
    logic        neg_q;
    logic        neg_r;

    // Low 32 bits of the shifted remainder; its bit 32 is rem_reg[31].
    assign trial_lo = {rem_reg[30:0], quo_reg[31]};

    cla32 u_sub (
        .a    (trial_lo),
        .b    (dmag_reg),
        .aluc (1'b1),
        .s    (diff),
        .cout (no_borrow)
    );

    assign take  = rem_reg[31] | no_borrow;
    assign neg_q = sgn_reg & (a_reg[31] ^ b_reg[31]);
    assign neg_r = sgn_reg & a_reg[31];

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        rem_next   = rem_reg;
        quo_next   = quo_reg;
        dmag_next  = dmag_reg;
        a_next     = a_reg;
        b_next     = b_reg;
        sgn_next   = sgn_reg;
        q_next     = q_reg;
        r_next     = r_reg;
        dz_next    = dz_reg;
        done_next  = 1'b0;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    a_next     = dividend;
                    b_next     = divisor;
                    sgn_next   = is_signed;
                    rem_next   = '0;
                    quo_next   = (is_signed && dividend[31]) ? -dividend : dividend;
                    dmag_next  = (is_signed && divisor[31])  ? -divisor  : divisor;
                    cnt_next   = '0;
                    state_next = CALC;
                end
            end
            CALC: begin
                rem_next = take ? diff : trial_lo;
                quo_next = {quo_reg[30:0], take};
                cnt_next = cnt_reg + 5'd1;
                if (cnt_reg == 5'd31) begin
                    state_next = FIX;
                end
            end
            FIX: begin
                // Divide-by-zero results bypass the sign fix-up entirely.
                if (b_reg == 32'd0) begin
                    q_next  = 32'hFFFF_FFFF;
                    r_next  = a_reg;
                    dz_next = 1'b1;
                end else begin
                    q_next  = neg_q ? -quo_reg : quo_reg;
                    r_next  = neg_r ? -rem_reg : rem_reg;
                    dz_next = 1'b0;
                end
                done_next  = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            rem_reg   <= '0;
            quo_reg   <= '0;
            dmag_reg  <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            sgn_reg   <= 1'b0;
            q_reg     <= '0;
            r_reg     <= '0;
            dz_reg    <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            rem_reg   <= rem_next;
            quo_reg   <= quo_next;
            dmag_reg  <= dmag_next;
            a_reg     <= a_next;
            b_reg     <= b_next;
            sgn_reg   <= sgn_next;
            q_reg     <= q_next;
            r_reg     <= r_next;
            dz_reg    <= dz_next;
            done_reg  <= done_next;
        end
    end

    assign q    = q_reg;
    assign r    = r_reg;
    assign dz   = dz_reg;
    assign done = done_reg;
    assign busy = (state_reg != IDLE);
endmodule
